// File: rtl/sqrt_result_credit_buffer.sv
// sqrt_result_credit_buffer
// Collects the non-stallable result stream of the sqrt formula distributor
// in a FIFO and hands it on through a valid/ready port. Credits (arg_rdy)
// cap the number of in-flight arguments plus held results at DEPTH, so a
// source that obeys arg_rdy can never overflow the FIFO.
// Optional build macro: SQRT_RESULT_BUFFER_ERR_EN adds a sticky `err` output
// that flags dropped pushes, arguments issued without credit and results
// arriving with nothing in flight.
module sqrt_result_credit_buffer #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arg_vld,
   output logic                       arg_rdy,
   input  logic                       res_vld,
   input  logic [WIDTH-1:0]           res,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
`ifdef SQRT_RESULT_BUFFER_ERR_EN
   ,
   output logic                       err
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW:0]   CRED_MAX = (CW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    inflight_r;
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;

   logic             pop_s;
   logic             full_s;
   logic             wr_en_s;
   logic [CW-1:0]    count_nxt_s;
   logic [CW-1:0]    inflight_nxt_s;
   logic [PW-1:0]    wr_ptr_nxt_s;
   logic [PW-1:0]    rd_ptr_nxt_s;
   logic [CW:0]      credit_sum_s;

   // Credits and head presentation derive from registered state only.
   always_comb begin
      credit_sum_s = {1'b0, inflight_r} + {1'b0, count_r};
      arg_rdy      = (credit_sum_s < CRED_MAX);
      out_vld      = (count_r != CNT_ZERO);
      out_data     = mem_r[rd_ptr_r];
      count        = count_r;
   end

   // Push/pop decisions and next-state values for pointers and counters.
   always_comb begin
      pop_s          = out_vld && out_rdy;
      full_s         = (count_r == CNT_FULL);
      // A push into a full FIFO only lands when a pop frees the slot the same cycle.
      wr_en_s        = res_vld && (!full_s || pop_s);
      count_nxt_s    = count_r;
      inflight_nxt_s = inflight_r;
      wr_ptr_nxt_s   = wr_ptr_r;
      rd_ptr_nxt_s   = rd_ptr_r;

      case ({wr_en_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase

      // Pointers wrap explicitly so DEPTH need not be a power of two.
      if (wr_en_s) begin
         if (wr_ptr_r == PTR_LAST) begin
            wr_ptr_nxt_s = PTR_ZERO;
         end else begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
         end
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end

      if (pop_s) begin
         if (rd_ptr_r == PTR_LAST) begin
            rd_ptr_nxt_s = PTR_ZERO;
         end else begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
         end
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end

      // In-flight count: saturates at DEPTH going up and at zero going down.
      case ({arg_vld, res_vld})
         2'b10: begin
            if (inflight_r != CNT_FULL) begin
               inflight_nxt_s = inflight_r + CNT_ONE;
            end else begin
               inflight_nxt_s = inflight_r;
            end
         end
         2'b01: begin
            if (inflight_r != CNT_ZERO) begin
               inflight_nxt_s = inflight_r - CNT_ONE;
            end else begin
               inflight_nxt_s = inflight_r;
            end
         end
         default: inflight_nxt_s = inflight_r;
      endcase
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r    <= CNT_ZERO;
         inflight_r <= CNT_ZERO;
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
      end else begin
         count_r    <= count_nxt_s;
         inflight_r <= inflight_nxt_s;
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
      end
   end

   // Result storage; contents are don't-care after reset so no reset is applied.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= res;
      end
   end

`ifdef SQRT_RESULT_BUFFER_ERR_EN
   logic err_r;
   logic viol_s;

   // Any protocol violation seen this cycle.
   always_comb begin
      viol_s = (res_vld && full_s && !pop_s) ||
               (arg_vld && !arg_rdy) ||
               (res_vld && (inflight_r == CNT_ZERO));
      err    = err_r;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (viol_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end
`endif

endmodule

// File: tb/tb_sqrt_result_credit_buffer.sv
// tb_sqrt_result_credit_buffer
// Self-checking bench: a queue-based reference model of the buffer and a
// fixed-latency distributor model drive directed and random traffic.
module tb_sqrt_result_credit_buffer;

   localparam int DEPTH = 16;
   localparam int WIDTH = 32;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             arg_vld = 1'b0;
   logic             arg_rdy;
   logic             res_vld = 1'b0;
   logic [WIDTH-1:0] res = 32'h0;
   logic             out_vld;
   logic             out_rdy = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    count;
`ifdef SQRT_RESULT_BUFFER_ERR_EN
   logic             err;
`endif

   sqrt_result_credit_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .arg_vld  (arg_vld),
      .arg_rdy  (arg_rdy),
      .res_vld  (res_vld),
      .res      (res),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .count    (count)
`ifdef SQRT_RESULT_BUFFER_ERR_EN
      ,
      .err      (err)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: FIFO contents, in-flight arguments, sticky error
   logic [31:0] mq[$];
   int          m_infl = 0;
   bit          m_err = 1'b0;
   int          cycle_n = 0;
   bit          last_rv = 1'b0;
   logic [31:0] dut_log[$];

   typedef struct packed {
      int          due;
      logic [31:0] d;
   } pend_t;
   pend_t       pend[$];
   int          lat = 1;
   logic [31:0] next_data = 32'h0;
   int          issued = 0;

   function automatic bit m_rdy();
      return (m_infl + mq.size()) < DEPTH;
   endfunction

   // one clock with the given inputs; model updated at the edge, outputs checked after it
   task automatic cyc(input bit av, input bit rv, input logic [31:0] rd, input bit ordy);
      bit pop, full, viol;
      arg_vld = av; res_vld = rv; res = rd; out_rdy = ordy;
      if (out_vld && ordy) dut_log.push_back(out_data);
      pop  = (mq.size() != 0) && ordy;
      full = (mq.size() == DEPTH);
      viol = (av && !m_rdy()) || (rv && m_infl == 0) || (rv && full && !pop);
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (rv && (!full || pop)) mq.push_back(rd);
      if (av && !rv) begin
         if (m_infl < DEPTH) m_infl++;
      end else if (rv && !av && m_infl > 0) begin
         m_infl--;
      end
      if (viol) m_err = 1'b1;
      last_rv = rv;
      cycle_n++;
      #1;
      check_eq("out_vld", 32'(out_vld), 32'(mq.size() != 0));
      check_eq("count", 32'(count), 32'(mq.size()));
      check_eq("arg_rdy", 32'(arg_rdy), 32'(m_rdy()));
      if (mq.size() != 0) check_eq("out_data", out_data, mq[0]);
`ifdef SQRT_RESULT_BUFFER_ERR_EN
      check_eq("err", 32'(err), 32'(m_err));
`endif
   endtask

   // distributor model: issues when credit allows, returns results after lat cycles
   task automatic dist_cycle(input bit want, input bit ordy);
      bit rv, av;
      logic [31:0] rd;
      rv = (pend.size() != 0) && (pend[0].due == cycle_n);
      rd = rv ? pend[0].d : 32'h0;
      if (rv) void'(pend.pop_front());
      av = want && arg_rdy;
      if (av) begin
         pend.push_back('{cycle_n + lat, next_data});
         next_data++;
         issued++;
      end
      cyc(av, rv, rd, ordy);
   endtask

   // async reset: checks the immediate clear, then releases on a falling edge
   task automatic do_reset();
      rst = 1'b1; arg_vld = 1'b0; res_vld = 1'b0; out_rdy = 1'b0;
      #1;
      check_eq("rst_count", 32'(count), 32'h0);
      check_eq("rst_out_vld", 32'(out_vld), 32'h0);
      check_eq("rst_arg_rdy", 32'(arg_rdy), 32'h1);
`ifdef SQRT_RESULT_BUFFER_ERR_EN
      check_eq("rst_err", 32'(err), 32'h0);
`endif
      mq.delete(); pend.delete(); dut_log.delete();
      m_infl = 0; m_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int vld_n;
      #2;
      do_reset();
      check_eq("rel_arg_rdy", 32'(arg_rdy), 32'h1);
      check_eq("rel_out_vld", 32'(out_vld), 32'h0);
      check_eq("rel_count", 32'(count), 32'h0);

      // passthrough: one argument, result 50 cycles later
      lat = 50; next_data = 32'h7; issued = 0; vld_n = 0;
      dist_cycle(1'b1, 1'b1);
      for (int i = 0; i < 60; i++) begin
         dist_cycle(1'b0, 1'b1);
         if (out_vld) begin
            vld_n++;
            check_eq("pt_after_res", 32'(last_rv), 32'h1);
            check_eq("pt_data", out_data, 32'h7);
         end
      end
      check_eq("pt_vld_cycles", vld_n, 32'h1);
      check_eq("pt_count", 32'(count), 32'h0);
      check_eq("pt_arg_rdy", 32'(arg_rdy), 32'h1);

      // credit exhaustion with a stalled consumer
      do_reset();
      lat = 30; next_data = 32'h1; issued = 0;
      for (int i = 0; i < 25; i++) dist_cycle(1'b1, 1'b0);
      check_eq("cr_issued", issued, 32'd16);
      check_eq("cr_arg_rdy_lo", 32'(arg_rdy), 32'h0);
      for (int i = 0; i < 25; i++) dist_cycle(1'b1, 1'b0);
      check_eq("cr_count_full", 32'(count), 32'd16);
      check_eq("cr_arg_rdy_full", 32'(arg_rdy), 32'h0);
      dist_cycle(1'b0, 1'b1);
      check_eq("cr_arg_rdy_pop", 32'(arg_rdy), 32'h1);
      for (int i = 0; i < 20; i++) dist_cycle(1'b0, 1'b1);
      check_eq("cr_drain_n", dut_log.size(), 32'd16);
      for (int i = 0; i < dut_log.size(); i++) check_eq("cr_order", dut_log[i], 32'(i + 1));

      // full FIFO: dropped push, then simultaneous push+pop
      do_reset();
      for (int d = 1; d <= 16; d++) cyc(1'b0, 1'b1, 32'(d), 1'b0);
      check_eq("ff_count", 32'(count), 32'd16);
      cyc(1'b0, 1'b1, 32'h99, 1'b0);
      check_eq("drop_count", 32'(count), 32'd16);
      for (int d = 17; d <= 20; d++) begin
         cyc(1'b0, 1'b1, 32'(d), 1'b1);
         check_eq("fpp_count", 32'(count), 32'd16);
      end
`ifdef SQRT_RESULT_BUFFER_ERR_EN
      check_eq("ff_err", 32'(err), 32'h1);
`endif
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("fpp_drain_n", dut_log.size(), 32'd20);
      for (int i = 0; i < dut_log.size(); i++) check_eq("fpp_order", dut_log[i], 32'(i + 1));

      // reset in the middle of traffic
      cyc(1'b0, 1'b1, 32'h5, 1'b0);
      cyc(1'b0, 1'b1, 32'h6, 1'b0);
      do_reset();

      // random consumer, 1000 credited issues
      lat = 7; next_data = 32'h1000; issued = 0;
      for (int i = 0; i < 20000 && issued < 1000; i++)
         dist_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 200 && (pend.size() != 0 || mq.size() != 0); i++)
         dist_cycle(1'b0, 1'b1);
      check_eq("rnd_issued", issued, 32'd1000);
      check_eq("rnd_out_n", dut_log.size(), 32'd1000);
      for (int i = 0; i < dut_log.size(); i++) check_eq("rnd_order", dut_log[i], 32'h1000 + 32'(i));
`ifdef SQRT_RESULT_BUFFER_ERR_EN
      check_eq("rnd_err", 32'(err), 32'h0);

      // argument without credit
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      check_eq("nocred_pre", 32'(err), 32'h0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      check_eq("nocred_err", 32'(err), 32'h1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
      check_eq("nocred_sticky", 32'(err), 32'h1);

      // result with nothing in flight
      do_reset();
      cyc(1'b0, 1'b1, 32'h5, 1'b1);
      check_eq("orphan_err", 32'(err), 32'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
